pwm_dac_multi: RTL and testbench



---
 rtl/pwm_dac_pkg.sv | 31 +++
 rtl/pwm_dac_ch.sv | 94 +++++++++
 rtl/pwm_dac_multi.sv | 144 ++++++++++++++
 tb/tb_pwm_dac_multi.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_dac_pkg.sv
// Shared definitions for the multi-channel PWM DAC.
//   AddrChBase : offset of channel 0 value register (channel n at +4n)
//   AddrSrc    : source-select mask register (bit n = 1 selects stream)
//   AddrEn     : output-enable mask register
//   bitrev()   : reverses the low w bits of a value (w <= RevMaxW)
// The fractional dither feature is built only when PWM_DITHER_EN is defined.
package pwm_dac_pkg;

  localparam logic [19:0] AddrChBase = 20'h20;
  localparam logic [19:0] AddrSrc    = 20'h40;
  localparam logic [19:0] AddrEn     = 20'h44;

  localparam int unsigned RevMaxW = 16;

  function automatic logic [RevMaxW-1:0] bitrev(input logic [RevMaxW-1:0] v,
                                                input int unsigned        w);
    logic [RevMaxW-1:0] r;
    logic [3:0]         dst;
    logic [3:0]         src;
    r = '0;
    for (int unsigned i = 0; i < RevMaxW; i++) begin
      dst = 4'(i);
      src = 4'(w - 1 - i);
      if (i < w) begin
        r[dst] = v[src];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_dac_ch.sv
// One PWM DAC channel: source mux, double-buffered active value, optional
// dither compare and registered output.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load         : high in the last cycle of a PWM period (cnt == 2^CW-1)
//   cnt          : shared period counter
//   ph_rev       : bit-reversed phase counter (PWM_DITHER_EN builds only)
//   reg_val      : bus-written channel value (duty:frac)
//   dat          : signed streaming sample
//   src_sel      : 1 selects the stream, 0 the register
//   en           : output enable
//   pwm          : registered PWM output
// Macro PWM_DITHER_EN enables the fractional dither.
module pwm_dac_ch
  import pwm_dac_pkg::*;
#(
  parameter int unsigned CW = 8,
  parameter int unsigned DW = 4,
  parameter int unsigned IW = 14
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic [CW-1:0]    cnt,
`ifdef PWM_DITHER_EN
  input  logic [DW-1:0]    ph_rev,
`endif
  input  logic [CW+DW-1:0] reg_val,
  input  logic [IW-1:0]    dat,
  input  logic             src_sel,
  input  logic             en,
  output logic             pwm
);

  localparam int unsigned VW = CW + DW;

  logic [IW-1:0] dat_ob;
  logic [VW-1:0] strm_val;
  logic [VW-1:0] sel;
  logic [CW-1:0] duty_q;
  logic          extra;
  logic [CW:0]   thresh;
  logic          pwm_q;

  // Signed to offset binary, keep the top VW bits.
  assign dat_ob   = {~dat[IW-1], dat[IW-2:0]};
  assign strm_val = dat_ob[IW-1 -: VW];
  assign sel      = src_sel ? strm_val : reg_val;

  // Low stream bits below the DAC resolution are dropped on purpose.
  logic unused_dat;
  assign unused_dat = ^dat_ob;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      duty_q <= '0;
    end else if (load) begin
      duty_q <= sel[VW-1:DW];
    end
  end

`ifdef PWM_DITHER_EN
  logic [DW-1:0] frac_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frac_q <= '0;
    end else if (load) begin
      frac_q <= sel[DW-1:0];
    end
  end

  // Bit-reversed phase spreads the lengthened periods evenly.
  assign extra = (ph_rev < frac_q);
`else
  assign extra = 1'b0;

  logic unused_frac;
  assign unused_frac = ^sel[DW-1:0];
`endif

  // One extra bit so duty = 2^CW-1 plus extra reaches a constant high.
  assign thresh = {1'b0, duty_q} + {{CW{1'b0}}, extra};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= en & ({1'b0, cnt} < thresh);
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/pwm_dac_multi.sv
// Multi-channel PWM DAC with bus-programmable values and streaming input.
//   clk_i, rst_i : clock, synchronous active-high reset
//   dat_i        : NCH signed stream samples, channel n at [n*IW +: IW]
//   pwm_o        : NCH PWM outputs
//   sys_addr, sys_wdata, sys_wen, sys_ren : bus request
//   sys_rdata, sys_ack, sys_err           : bus response (one cycle later)
// Holds the period/phase counters, register file and bus decode; one
// pwm_dac_ch per channel. Macro PWM_DITHER_EN enables fractional dither.
module pwm_dac_multi
  import pwm_dac_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 8,
  parameter int unsigned DW  = 4,
  parameter int unsigned IW  = 14
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NCH*IW-1:0] dat_i,
  output logic [NCH-1:0]    pwm_o,
  input  logic [31:0]       sys_addr,
  input  logic [31:0]       sys_wdata,
  input  logic              sys_wen,
  input  logic              sys_ren,
  output logic [31:0]       sys_rdata,
  output logic              sys_err,
  output logic              sys_ack
);

  localparam int unsigned VW = CW + DW;

  logic [CW-1:0]  cnt_q;
  logic           load;
  logic [VW-1:0]  val_q [NCH];
  logic [NCH-1:0] src_q;
  logic [NCH-1:0] en_q;
  logic           ack_q;
  logic [31:0]    rdata_q;
  logic [31:0]    rdata_d;
  logic [19:0]    addr;

  assign addr = sys_addr[19:0];
  assign load = (cnt_q == '1);

  logic unused_bus;
  assign unused_bus = ^{sys_addr, sys_wdata};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

`ifdef PWM_DITHER_EN
  logic [DW-1:0] ph_q;
  logic [DW-1:0] ph_rev;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ph_q <= '0;
    end else if (load) begin
      ph_q <= ph_q + DW'(1);
    end
  end

  assign ph_rev = DW'(bitrev(RevMaxW'(ph_q), DW));
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NCH; i++) begin
        val_q[i] <= '0;
      end
      src_q <= '0;
      en_q  <= '0;
    end else if (sys_wen) begin
      for (int i = 0; i < NCH; i++) begin
        if (addr == AddrChBase + 20'(4 * i)) begin
          val_q[i] <= sys_wdata[VW-1:0];
        end
      end
      if (addr == AddrSrc) begin
        src_q <= sys_wdata[NCH-1:0];
      end
      if (addr == AddrEn) begin
        en_q <= sys_wdata[NCH-1:0];
      end
    end
  end

  // Read mux sees pre-write values, so a same-cycle write returns old data.
  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (addr == AddrChBase + 20'(4 * i)) begin
        rdata_d = 32'(val_q[i]);
      end
    end
    if (addr == AddrSrc) begin
      rdata_d = 32'(src_q);
    end
    if (addr == AddrEn) begin
      rdata_d = 32'(en_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= sys_wen | sys_ren;
      rdata_q <= sys_ren ? rdata_d : '0;
    end
  end

  assign sys_ack   = ack_q;
  assign sys_rdata = rdata_q;
  assign sys_err   = 1'b0;

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    pwm_dac_ch #(
      .CW(CW),
      .DW(DW),
      .IW(IW)
    ) u_ch (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load   (load),
      .cnt    (cnt_q),
`ifdef PWM_DITHER_EN
      .ph_rev (ph_rev),
`endif
      .reg_val(val_q[n]),
      .dat    (dat_i[n*IW +: IW]),
      .src_sel(src_q[n]),
      .en     (en_q[n]),
      .pwm    (pwm_o[n])
    );
  end

endmodule

// File: tb/tb_pwm_dac_multi.sv
// Self-checking bench for pwm_dac_multi (defaults NCH=4, CW=8, DW=4, IW=14).
// Expected PWM behaviour is derived per period: high for the first
// duty+extra cycles, with the value captured at the period boundary.
module tb_pwm_dac_multi;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int DW  = 4;
  localparam int IW  = 14;
  localparam int PER = 1 << CW;
  localparam int NPH = 1 << DW;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NCH*IW-1:0] dat_i;
  logic [NCH-1:0]    pwm_o;
  logic [31:0]       sys_addr;
  logic [31:0]       sys_wdata;
  logic              sys_wen;
  logic              sys_ren;
  logic [31:0]       sys_rdata;
  logic              sys_err;
  logic              sys_ack;

  int vectors     = 0;
  int miscompares = 0;
  int k;                       // clock edges since reset release

  int unsigned sh_val   [NCH]; // bus-visible register model
  int unsigned prev_val [NCH];
  int          last_wr_k[NCH];
  int unsigned sh_src;
  int unsigned sh_en;
  int unsigned strm     [NCH]; // raw 14-bit stream samples
  int          last_highs[NCH];
  int          total;

  always #5 clk_i = ~clk_i;

  pwm_dac_multi #(
    .NCH(NCH),
    .CW (CW),
    .DW (DW),
    .IW (IW)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .dat_i    (dat_i),
    .pwm_o    (pwm_o),
    .sys_addr (sys_addr),
    .sys_wdata(sys_wdata),
    .sys_wen  (sys_wen),
    .sys_ren  (sys_ren),
    .sys_rdata(sys_rdata),
    .sys_err  (sys_err),
    .sys_ack  (sys_ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    k++;
  endtask

  function automatic int rev_ph(input int p);
    int r = 0;
    for (int i = 0; i < DW; i++) begin
      if (((p >> i) & 1) != 0) r = r | (1 << (DW - 1 - i));
    end
    return r;
  endfunction

  // High cycles in a period for a given duty:frac value and period index.
  function automatic int thresh(input int unsigned v, input int p);
    int t;
    t = int'(v >> DW);
`ifdef PWM_DITHER_EN
    if (rev_ph(p % NPH) < int'(v % NPH)) t = t + 1;
`endif
    return t;
  endfunction

  function automatic int unsigned stream_val(input int unsigned s);
    return ((s + (1 << (IW - 1))) % (1 << IW)) >> (IW - CW - DW);
  endfunction

  function automatic logic [31:0] reg_model(input logic [31:0] a);
    logic [31:0] r = 32'h0;
    for (int n = 0; n < NCH; n++) begin
      if (a == 32'(32'h20 + 4 * n)) r = sh_val[n];
    end
    if (a == 32'h40) r = sh_src;
    if (a == 32'h44) r = sh_en;
    return r;
  endfunction

  task automatic shadow_write(input logic [31:0] a, input logic [31:0] d);
    for (int n = 0; n < NCH; n++) begin
      if (a == 32'(32'h20 + 4 * n)) begin
        prev_val[n]  = sh_val[n];
        last_wr_k[n] = k;
        sh_val[n]    = d & 32'hFFF;
      end
    end
    if (a == 32'h40) sh_src = d & 32'hF;
    if (a == 32'h44) sh_en = d & 32'hF;
  endtask

  task automatic shadow_clear();
    for (int n = 0; n < NCH; n++) begin
      sh_val[n]    = 0;
      prev_val[n]  = 0;
      last_wr_k[n] = -1;
    end
    sh_src = 0;
    sh_en  = 0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    sys_addr  = a;
    sys_wdata = d;
    sys_wen   = 1'b1;
    tick();
    sys_wen = 1'b0;
    check($sformatf("wr_ack_%0h", a), 32'(sys_ack), 32'h1);
    check($sformatf("wr_err_%0h", a), 32'(sys_err), 32'h0);
    shadow_write(a, d);
  endtask

  task automatic bus_read(input logic [31:0] a);
    logic [31:0] exp;
    exp      = reg_model(a);
    sys_addr = a;
    sys_ren  = 1'b1;
    tick();
    sys_ren = 1'b0;
    check($sformatf("rd_ack_%0h", a), 32'(sys_ack), 32'h1);
    check($sformatf("rd_data_%0h", a), sys_rdata, exp);
  endtask

  task automatic set_dat(input int n, input int unsigned v);
    dat_i[n*IW +: IW] = IW'(v);
    strm[n] = v % (1 << IW);
  endtask

  task automatic wait_boundary();
    do tick(); while (k % PER != 0);
  endtask

  // Observe one whole period starting at a boundary; optionally write the
  // channel 0 register or pulse reset at cnt = 100.
  task automatic measure_period(input bit mid_wr, input logic [31:0] wr_data, input bit mid_rst);
    int p;
    int th[NCH];
    int first_low[NCH];
    int unsigned v;
    p = k / PER;
    for (int n = 0; n < NCH; n++) begin
      v = (last_wr_k[n] == k) ? prev_val[n] : sh_val[n];
      if (((sh_src >> n) & 1) != 0) v = stream_val(strm[n]);
      th[n]         = (((sh_en >> n) & 1) != 0) ? thresh(v, p) : 0;
      last_highs[n] = 0;
      first_low[n]  = PER;
    end
    for (int pos = 0; pos < PER; pos++) begin
      if (mid_wr && pos == 100) begin
        sys_addr  = 32'h20;
        sys_wdata = wr_data;
        sys_wen   = 1'b1;
      end
      if (mid_rst && pos == 100) rst_i = 1'b1;
      tick();
      sys_wen = 1'b0;
      if (mid_wr && pos == 100) begin
        check("mid_wr_ack", 32'(sys_ack), 32'h1);
        shadow_write(32'h20, wr_data);
      end
      if (mid_rst && pos == 100) begin
        check("mid_rst_pwm", 32'(pwm_o), 32'h0);
        check("mid_rst_ack", 32'(sys_ack), 32'h0);
        rst_i = 1'b0;
        k     = 0;
        shadow_clear();
        return;
      end
      for (int n = 0; n < NCH; n++) begin
        if (pwm_o[n] === 1'b1) last_highs[n]++;
        else if (first_low[n] == PER) first_low[n] = pos;
      end
    end
    for (int n = 0; n < NCH; n++) begin
      check($sformatf("highs_ch%0d_p%0d", n, p), 32'(last_highs[n]), 32'(th[n]));
      check($sformatf("edge_ch%0d_p%0d", n, p), 32'(first_low[n]), 32'(th[n]));
    end
  endtask

  initial begin
    logic [31:0] old;
    rst_i     = 1'b1;
    sys_addr  = '0;
    sys_wdata = '0;
    sys_wen   = 1'b0;
    sys_ren   = 1'b0;
    dat_i     = '0;
    k         = 0;
    total     = 0;
    shadow_clear();
    for (int n = 0; n < NCH; n++) strm[n] = 0;

    // Reset
    repeat (4) @(negedge clk_i);
    check("rst_pwm", 32'(pwm_o), 32'h0);
    check("rst_ack", 32'(sys_ack), 32'h0);
    check("rst_err", 32'(sys_err), 32'h0);
    check("rst_rdata", sys_rdata, 32'h0);
    rst_i = 1'b0;
    k     = 0;
    bus_read(32'h20);
    bus_read(32'h40);
    bus_read(32'h44);
    tick();
    check("ack_idle", 32'(sys_ack), 32'h0);

    // Basic duty
    bus_write(32'h20, 32'h400);
    bus_write(32'h44, 32'h1);
    wait_boundary();
    measure_period(1'b0, 32'h0, 1'b0);
    check("basic_64", 32'(last_highs[0]), 32'd64);
    measure_period(1'b0, 32'h0, 1'b0);

    // Dither over a full phase cycle
    bus_write(32'h20, 32'h401);
    wait_boundary();
    total = 0;
    for (int i = 0; i < NPH; i++) begin
      measure_period(1'b0, 32'h0, 1'b0);
      total += last_highs[0];
    end
`ifdef PWM_DITHER_EN
    check("dither_total", 32'(total), 32'd1025);
`else
    check("dither_total", 32'(total), 32'd1024);
`endif

    // Full scale
    bus_write(32'h20, 32'hFFF);
    wait_boundary();
    total = 0;
    for (int i = 0; i < NPH; i++) begin
      measure_period(1'b0, 32'h0, 1'b0);
      total += last_highs[0];
    end
`ifdef PWM_DITHER_EN
    check("full_total", 32'(total), 32'd4095);
`else
    check("full_total", 32'(total), 32'd4080);
`endif

    // Stream source on channel 1
    bus_write(32'h40, 32'h2);
    bus_write(32'h44, 32'h2);
    set_dat(1, 32'h2000);
    wait_boundary();
    measure_period(1'b0, 32'h0, 1'b0);
    check("strm_min", 32'(last_highs[1]), 32'd0);
    set_dat(1, 0);
    wait_boundary();
    measure_period(1'b0, 32'h0, 1'b0);
    check("strm_mid", 32'(last_highs[1]), 32'd128);

    // Mid-period update, then mid-period reset
    bus_write(32'h40, 32'h0);
    bus_write(32'h44, 32'h1);
    bus_write(32'h20, 32'h400);
    wait_boundary();
    measure_period(1'b1, 32'h800, 1'b0);
    check("mid_keep_64", 32'(last_highs[0]), 32'd64);
    measure_period(1'b0, 32'h0, 1'b0);
    check("mid_next_128", 32'(last_highs[0]), 32'd128);
    measure_period(1'b0, 32'h0, 1'b1);
    bus_read(32'h20);
    bus_read(32'h44);
    bus_write(32'h20, 32'h300);
    bus_write(32'h44, 32'h1);
    wait_boundary();
    measure_period(1'b0, 32'h0, 1'b0);

    // Bus corners: unmapped address, masking, simultaneous read/write
    bus_write(32'h100, 32'hFFFF_FFFF);
    bus_read(32'h100);
    bus_write(32'h24, 32'hFFFF_FFFF);
    bus_read(32'h24);
    old       = reg_model(32'h24);
    sys_addr  = 32'h24;
    sys_wdata = 32'h5A5;
    sys_wen   = 1'b1;
    sys_ren   = 1'b1;
    tick();
    sys_wen = 1'b0;
    sys_ren = 1'b0;
    check("rw_old", sys_rdata, old);
    shadow_write(32'h24, 32'h5A5);
    bus_read(32'h24);

    // Write landing in the load cycle is deferred one period
    bus_write(32'h44, 32'hF);
    do tick(); while (k % PER != PER - 1);
    bus_write(32'h20, 32'hA00);
    measure_period(1'b0, 32'h0, 1'b0);
    check("load_cyc_old", 32'(last_highs[0]), 32'd48);
    measure_period(1'b0, 32'h0, 1'b0);
    check("load_cyc_new", 32'(last_highs[0]), 32'd160);

    // Randomized configurations
    for (int t = 0; t < 10; t++) begin
      for (int n = 0; n < NCH; n++) begin
        if (t % 3 == 0) bus_write(32'(32'h20 + 4 * n), $urandom());
        else bus_write(32'(32'h20 + 4 * n), 32'($urandom_range(0, 4095)));
        set_dat(n, $urandom_range(0, (1 << IW) - 1));
      end
      bus_write(32'h40, 32'($urandom_range(0, 15)));
      bus_write(32'h44, 32'($urandom_range(0, 15)));
      for (int n = 0; n < NCH; n++) bus_read(32'(32'h20 + 4 * n));
      bus_read(32'h40);
      bus_read(32'h44);
      wait_boundary();
      measure_period(1'b0, 32'h0, 1'b0);
      measure_period(1'b0, 32'h0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
